// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling unit.
// Holds the FSM state encoding and the control-strobe bundle passed to the datapath.
package rc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int KEY_BYTES_DEF = 3;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    READ_I,
    CAPT_I,
    READ_J,
    CAPT_J,
    WRITE_J,
    WRITE_I,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DSEL_I,
    DSEL_SI,
    DSEL_SJ
  } data_sel_t;

  // One-cycle strobes decoded from the current state.
  typedef struct packed {
    logic      load;      // accept start: register key, clear i/j/key index
    logic      i_inc;
    logic      k_inc;
    logic      j_upd;
    logic      si_ld;
    logic      sj_ld;
    logic      addr_j;    // address comes from j instead of i
    data_sel_t data_sel;
  } ctrl_t;

endpackage

// File: rtl/ksa_unit_if.sv
// Handshake and S-memory bus of the key-scheduling unit.
// The slave side is the scheduler; the master side owns start/key and the S memory.
interface ksa_unit_if #(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEF
);

  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
  logic                   ready;
  logic                   done;
  logic [7:0]             addr_to_s_mem;
  logic [7:0]             data_to_s_mem;
  logic                   wren_s_mem;
  logic [7:0]             data_from_s_mem;

  modport master (
    output start, key, data_from_s_mem,
    input  ready, done, addr_to_s_mem, data_to_s_mem, wren_s_mem
  );

  modport slave (
    input  start, key, data_from_s_mem,
    output ready, done, addr_to_s_mem, data_to_s_mem, wren_s_mem
  );

endinterface

// File: rtl/ksa_datapath.sv
// Index/swap registers and S-memory address/data muxing for the RC4 key schedule.
// Every register moves only on a control strobe from the FSM.
module ksa_datapath
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             rdata,
  input  ctrl_t                  ctrl,
  output logic [7:0]             addr,
  output logic [7:0]             data,
  output logic                   i_last
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [7:0]             i, j, s_i, s_j;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [KIDX_W-1:0]      kidx;
  logic [7:0]             key_byte;

  // kidx tracks i mod KEY_BYTES incrementally instead of dividing i.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIDX_W'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i     <= '0;
      j     <= '0;
      s_i   <= '0;
      s_j   <= '0;
      key_q <= '0;
      kidx  <= '0;
    end else begin
      if (ctrl.load) begin
        key_q <= key;
        i     <= '0;
        j     <= '0;
        kidx  <= '0;
      end
      if (ctrl.i_inc) i <= i + 8'd1;
      if (ctrl.k_inc) kidx <= (kidx == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx + KIDX_W'(1);
      if (ctrl.j_upd) j <= j + rdata + key_byte;
      if (ctrl.si_ld) s_i <= rdata;
      if (ctrl.sj_ld) s_j <= rdata;
    end
  end

  assign i_last = (i == 8'(S_DEPTH-1));
  assign addr   = ctrl.addr_j ? j : i;

  always_comb begin
    unique case (ctrl.data_sel)
      DSEL_SI: data = s_i;
      DSEL_SJ: data = s_j;
      default: data = i;
    endcase
  end

endmodule

// File: rtl/ksa_unit.sv
// RC4 key-scheduling unit: fills S with the identity, then runs the 256-step keyed swap.
// One FSM drives the datapath strobes; ready/done/wren are registered.
module ksa_unit
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic      clk,
  input  logic      rst,
  ksa_unit_if.slave bus
);

  state_t state;
  ctrl_t  ctrl;
  logic   ready_q, done_q, wren_q;
  logic   i_last;

  always_comb begin
    ctrl          = '0;
    ctrl.data_sel = DSEL_I;
    unique case (state)
      IDLE:    ctrl.load  = bus.start;
      INIT:    ctrl.i_inc = 1'b1;
      CAPT_I: begin
        ctrl.si_ld = 1'b1;
        ctrl.j_upd = 1'b1;
      end
      READ_J:  ctrl.addr_j = 1'b1;
      CAPT_J: begin
        ctrl.addr_j = 1'b1;
        ctrl.sj_ld  = 1'b1;
      end
      WRITE_J: begin
        ctrl.addr_j   = 1'b1;
        ctrl.data_sel = DSEL_SI;
      end
      WRITE_I: begin
        ctrl.i_inc    = 1'b1;
        ctrl.k_inc    = 1'b1;
        ctrl.data_sel = DSEL_SJ;
      end
      default: ;
    endcase
  end

  // Registered outputs are set on the edge entering the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          state   <= INIT;
          ready_q <= 1'b0;
          wren_q  <= 1'b1;
        end
        INIT: if (i_last) begin
          state  <= READ_I;
          wren_q <= 1'b0;
        end
        READ_I: state <= CAPT_I;
        CAPT_I: state <= READ_J;
        READ_J: state <= CAPT_J;
        CAPT_J: begin
          state  <= WRITE_J;
          wren_q <= 1'b1;
        end
        WRITE_J: state <= WRITE_I;
        WRITE_I: begin
          wren_q <= 1'b0;
          if (i_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= READ_I;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

  ksa_datapath #(.KEY_BYTES(KEY_BYTES)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .key    (bus.key),
    .rdata  (bus.data_from_s_mem),
    .ctrl   (ctrl),
    .addr   (bus.addr_to_s_mem),
    .data   (bus.data_to_s_mem),
    .i_last (i_last)
  );

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.wren_s_mem = wren_q;

endmodule

// File: tb/tb_ksa_unit.sv
// Bench for ksa_unit: cycle-by-cycle bus trace and final S contents checked against an RC4 KSA model.
// dut_a uses KEY_BYTES=3, dut_b uses KEY_BYTES=5.
module tb_ksa_unit;

  localparam int RUN = 1794;  // accept edge -> first IDLE cycle after done

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ksa_unit_if #(.KEY_BYTES(3)) bus_a ();
  ksa_unit_if #(.KEY_BYTES(5)) bus_b ();

  ksa_unit #(.KEY_BYTES(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ksa_unit #(.KEY_BYTES(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Synchronous S memories: read data valid one cycle after the address.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (bus_a.wren_s_mem) mem_a[bus_a.addr_to_s_mem] <= bus_a.data_to_s_mem;
    bus_a.data_from_s_mem <= mem_a[bus_a.addr_to_s_mem];
    if (bus_b.wren_s_mem) mem_b[bus_b.addr_to_s_mem] <= bus_b.data_to_s_mem;
    bus_b.data_from_s_mem <= mem_b[bus_b.addr_to_s_mem];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bus activity per cycle after the accept edge, plus final S.
  bit exp_wren   [RUN+1];
  bit addr_cares [RUN+1];
  int exp_addr   [RUN+1];
  int exp_data   [RUN+1];
  bit exp_ready  [RUN+1];
  bit exp_done   [RUN+1];
  int model_s    [256];

  task automatic build_model(input logic [39:0] key_r, input int nkb);
    int j, c0, kb, t;
    for (int c = 0; c <= RUN; c++) begin
      exp_wren[c] = 0; addr_cares[c] = 0; exp_addr[c] = 0;
      exp_data[c] = 0; exp_ready[c] = 0; exp_done[c] = 0;
    end
    for (int k = 0; k < 256; k++) begin
      exp_wren[k+1] = 1; addr_cares[k+1] = 1;
      exp_addr[k+1] = k; exp_data[k+1] = k;
      model_s[k] = k;
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      c0 = 256 + 6*i;
      kb = int'(key_r[8*(nkb-1-(i % nkb)) +: 8]);
      addr_cares[c0+1] = 1; exp_addr[c0+1] = i;
      addr_cares[c0+2] = 1; exp_addr[c0+2] = i;
      j = (j + model_s[i] + kb) % 256;
      addr_cares[c0+3] = 1; exp_addr[c0+3] = j;
      addr_cares[c0+4] = 1; exp_addr[c0+4] = j;
      exp_wren[c0+5] = 1; addr_cares[c0+5] = 1; exp_addr[c0+5] = j; exp_data[c0+5] = model_s[i];
      exp_wren[c0+6] = 1; addr_cares[c0+6] = 1; exp_addr[c0+6] = i; exp_data[c0+6] = model_s[j];
      t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
    end
    exp_done[1793]  = 1;
    exp_ready[RUN]  = 1;
  endtask

  // Per-cycle compare of dut_a against the model while a run is tracked.
  bit mon_on = 0;
  int mon_n  = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      mon_n++;
      check($sformatf("c%0d ready", mon_n), 32'(bus_a.ready), 32'(exp_ready[mon_n]));
      check($sformatf("c%0d done", mon_n), 32'(bus_a.done), 32'(exp_done[mon_n]));
      check($sformatf("c%0d wren", mon_n), 32'(bus_a.wren_s_mem), 32'(exp_wren[mon_n]));
      if (addr_cares[mon_n])
        check($sformatf("c%0d addr", mon_n), 32'(bus_a.addr_to_s_mem), exp_addr[mon_n]);
      if (exp_wren[mon_n])
        check($sformatf("c%0d data", mon_n), 32'(bus_a.data_to_s_mem), exp_data[mon_n]);
      if (mon_n == RUN) mon_on = 0;
    end
  end

  // Called at a negedge with the model already built for key24.
  task automatic run_a(input logic [23:0] key24, input bit noisy);
    bus_a.key   = key24;
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 mon_n = 0; mon_on = 1;
    for (int n = 0; n < 3000 && mon_on; n++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      if (noisy && n < 1700) begin
        bus_a.start = (n % 97 == 3);
        bus_a.key   = 24'($urandom);
      end
    end
    bus_a.start = 1'b0;
    check("run_a completes", 32'(mon_on), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 256; k++)
      check($sformatf("key %06h S[%0d]", key24, k), 32'(mem_a[k]), model_s[k]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.key = '0;
    bus_b.start = 1'b0; bus_b.key = '0;
    #3;
    check("reset ready", 32'(bus_a.ready), 32'd1);
    check("reset done", 32'(bus_a.done), 32'd0);
    check("reset wren", 32'(bus_a.wren_s_mem), 32'd0);
    check("reset addr", 32'(bus_a.addr_to_s_mem), 32'd0);
    check("reset data", 32'(bus_a.data_to_s_mem), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero key, start on first edge after reset, with start/key noise while busy.
    build_model(40'h0, 3);
    check("pin k0 c273 addr", exp_addr[273], 3);
    check("pin k0 c273 data", exp_data[273], 2);
    check("pin k0 c274 addr", exp_addr[274], 2);
    check("pin k0 c274 data", exp_data[274], 3);
    check("pin k0 c261 addr", exp_addr[261], 0);
    check("pin done cycle", 32'(exp_done[1793]), 32'd1);
    check("pin ready low in DONE", 32'(exp_ready[1793]), 32'd0);
    run_a(24'h000000, 1'b1);

    build_model(40'h010203, 3);
    check("pin k010203 c261 addr", exp_addr[261], 1);
    check("pin k010203 c261 data", exp_data[261], 0);
    check("pin k010203 c262 addr", exp_addr[262], 0);
    check("pin k010203 c262 data", exp_data[262], 1);
    run_a(24'h010203, 1'b0);

    // Reset during shuffle: cycle 700 is a WRITE_I cycle.
    bus_a.key = 24'h010203; bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    repeat (699) @(posedge clk);
    #1 check("c700 wren before reset", 32'(bus_a.wren_s_mem), 32'(exp_wren[700]));
    #1 rst = 1'b1;
    #1;
    check("mid reset wren", 32'(bus_a.wren_s_mem), 32'd0);
    check("mid reset ready", 32'(bus_a.ready), 32'd1);
    check("mid reset done", 32'(bus_a.done), 32'd0);
    check("mid reset addr", 32'(bus_a.addr_to_s_mem), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("held reset wren", 32'(bus_a.wren_s_mem), 32'd0);
      check("held reset done", 32'(bus_a.done), 32'd0);
    end
    rst = 1'b0;
    build_model(40'hFFFFFF, 3);
    run_a(24'hFFFFFF, 1'b0);

    // Five-byte key on dut_b: latency and final S.
    build_model(40'h0102030405, 5);
    check("pin k5 c261 addr", exp_addr[261], 1);
    bus_b.key = 40'h0102030405; bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    lat = 0; got = 0;
    for (int n = 1; n <= 2500 && !got; n++) begin
      @(negedge clk);
      if (bus_b.done) begin
        got = 1; lat = n;
      end
    end
    check("k5 done seen", 32'(got), 32'd1);
    check("k5 latency", lat, 1793);
    @(negedge clk);
    check("k5 ready after done", 32'(bus_b.ready), 32'd1);
    for (int k = 0; k < 256; k++)
      check($sformatf("k5 S[%0d]", k), 32'(mem_b[k]), model_s[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
